// File: rtl/score_display.sv
// Score-to-display path: a sequential double-dabble converter latches the BCD of the score, and a
// refresh multiplexer drives a 4-digit common-anode 7-segment display from that latched value.
module score_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] score,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  state_e      state_q, state_d;
  logic [13:0] last_q, last_d;
  logic [13:0] value_q, value_d;
  logic        clamp_q, clamp_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] acc_q, acc_d, acc_adj;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        over_max;

  logic [CntW-1:0] refresh_q;
  logic [1:0]      digit_q;
  logic [3:0]      digit_val;
  logic            blank;
  logic [6:0]      seg_code;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (score != last_q) state_d = StShift;
      StShift: if (bit_cnt_q == 4'd13) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  // ---------------- datapath ----------------
  assign over_max = (score > 14'd9999);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
  end

  always_comb begin
    last_d    = last_q;
    value_d   = value_q;
    clamp_d   = clamp_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (score != last_q) begin
          last_d    = score;
          clamp_d   = over_max;
          value_d   = over_max ? 14'd9999 : score;
          bit_cnt_d = 4'd0;
          acc_d     = 16'd0;
        end
      end
      StShift: begin
        {acc_d, value_d} = {acc_adj, value_q} << 1;
        bit_cnt_d        = bit_cnt_q + 4'd1;
      end
      StDone: begin
        bcd_d = acc_q;
        ovf_d = clamp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= '0;
      value_q   <= '0;
      clamp_q   <= 1'b0;
      bit_cnt_q <= '0;
      acc_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      value_q   <= value_d;
      clamp_q   <= clamp_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd = bcd_q;
  assign ovf = ovf_q;

  // ---------------- display multiplexer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
    end else if (refresh_q == CntMax) begin
      refresh_q <= '0;
      digit_q   <= digit_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign an        = ~(4'b0001 << digit_q);
  assign digit_val = bcd_q[4*digit_q +: 4];

  always_comb begin
    blank = 1'b0;
    unique case (digit_q)
      2'd3: blank = BLANK_LZ && (bcd_q[15:12] == 4'd0);
      2'd2: blank = BLANK_LZ && (bcd_q[15:8] == 8'd0);
      2'd1: blank = BLANK_LZ && (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    seg_code = 7'b1111111;
    unique case (digit_val)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  end

  assign seg = blank ? 7'b1111111 : seg_code;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset state, conversion timing, clamping, blanking,
// back-to-back score changes, reset abort and a full 0..9995 sweep against a decimal reference.
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] score;
  logic [15:0] bcd, bcd_nb;
  logic        busy, busy_nb, ovf, ovf_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .score(score), .bcd(bcd), .busy(busy), .ovf(ovf),
    .an(an), .seg(seg)
  );

  // Same stimulus, leading zeros shown.
  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .score(score), .bcd(bcd_nb), .busy(busy_nb), .ovf(ovf_nb),
    .an(an_nb), .seg(seg_nb)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive a new score, then wait for the conversion to start and finish (bounded).
  task automatic apply(input int v, output bit ok);
    bit started = 0;
    bit done = 0;
    @(posedge clk); #1;
    score = 14'(v);
    for (int i = 0; i < 4 && !started; i++) begin
      @(negedge clk);
      if (busy === 1'b1) started = 1;
    end
    for (int i = 0; i < 24 && started && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    ok = started && done;
  endtask

  task automatic wait_digit(input int d, output bit found);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an === tgt) found = 1;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    reset = 1'b0;
    score = 14'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h exp 0000", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b exp 1000000", seg); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_an  = ~(4'b0001 << ((k / 4) % 4));
      exp_seg = (((k / 4) % 4) == 0) ? 7'b1000000 : 7'b1111111;
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg_blank k=%0d got %b exp %b", k, seg, exp_seg); end
      checks++; if (seg_nb !== 7'b1000000) begin errors++; $display("FAIL scan_seg_noblank k=%0d got %b exp 1000000", k, seg_nb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy k=%0d got %b exp 0", k, busy); end
      @(posedge clk);
    end
  endtask

  task automatic test_convert;
    logic [6:0] exp_seg [4];
    bit found;
    exp_seg = '{7'b0010010, 7'b0110000, 7'b0100100, 7'b1111001};
    @(posedge clk); #1;
    score = 14'd1235;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conv_busy_pre got %b exp 0", busy); end
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== (i <= 15)) begin
        errors++; $display("FAIL conv_busy edge+%0d got %b exp %b", i, busy, (i <= 15));
      end
      if (i == 15) begin
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL conv_bcd_early got %h exp 0000", bcd); end
      end
    end
    checks++; if (bcd !== 16'h1235) begin errors++; $display("FAIL conv_bcd got %h exp 1235", bcd); end
    for (int d = 0; d < 4; d++) begin
      wait_digit(d, found);
      checks++;
      if (!found) begin errors++; $display("FAIL conv_digit%0d_timeout got an=%b", d, an); end
      else if (seg !== exp_seg[d]) begin
        errors++; $display("FAIL conv_seg digit%0d got %b exp %b", d, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_clamp;
    int          vals [5];
    logic [15:0] exp_bcd [5];
    logic        exp_ovf [5];
    bit ok, found;
    logic [6:0] exp45 [4];
    logic [6:0] exp105 [4];
    vals    = '{9995, 10000, 16379, 45, 105};
    exp_bcd = '{16'h9995, 16'h9999, 16'h9999, 16'h0045, 16'h0105};
    exp_ovf = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp45   = '{7'b0010010, 7'b0011001, 7'b1111111, 7'b1111111};
    exp105  = '{7'b0010010, 7'b1000000, 7'b1111001, 7'b1111111};
    for (int n = 0; n < 5; n++) begin
      apply(vals[n], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clamp_timeout score=%0d got busy=%b", vals[n], busy); end
      checks++;
      if (bcd !== exp_bcd[n]) begin
        errors++; $display("FAIL clamp_bcd score=%0d got %h exp %h", vals[n], bcd, exp_bcd[n]);
      end
      checks++;
      if (ovf !== exp_ovf[n]) begin
        errors++; $display("FAIL clamp_ovf score=%0d got %b exp %b", vals[n], ovf, exp_ovf[n]);
      end
      if (n >= 3) begin
        for (int d = 0; d < 4; d++) begin
          wait_digit(d, found);
          checks++;
          if (!found) begin errors++; $display("FAIL blank_digit%0d_timeout got an=%b", d, an); end
          else if (seg !== ((n == 3) ? exp45[d] : exp105[d])) begin
            errors++;
            $display("FAIL blank_seg score=%0d digit%0d got %b exp %b", vals[n], d, seg,
                     (n == 3) ? exp45[d] : exp105[d]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] first = 16'h0105;
    bit seen = 0;
    bit done = 0;
    bit busy_seen = 0;
    @(posedge clk); #1; score = 14'd5;
    @(posedge clk); #1; score = 14'd10;
    @(posedge clk); #1; score = 14'd15;
    for (int n = 0; n < 31 && !done; n++) begin
      @(posedge clk); @(negedge clk);
      if (!seen && bcd !== 16'h0105) begin seen = 1; first = bcd; end
      if (bcd === 16'h0015) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_settle got %h exp 0015", bcd); end
    checks++;
    if (first !== 16'h0005 && first !== 16'h0010) begin
      errors++; $display("FAIL b2b_first got %h exp 0005 or 0010", first);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1;
    end
    checks++; if (busy_seen) begin errors++; $display("FAIL b2b_extra_conv got busy=1 exp 0"); end
  endtask

  task automatic test_reset_abort;
    @(posedge clk); #1;
    score = 14'd2500;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL abort_bcd got %h exp 0000", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b exp 0", ovf); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL abort_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL abort_seg got %b exp 1000000", seg); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 15) begin
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL abort_bcd_early got %h exp 0000", bcd); end
      end
    end
    checks++; if (bcd !== 16'h2500) begin errors++; $display("FAIL abort_bcd_after got %h exp 2500", bcd); end
  endtask

  task automatic test_sweep;
    bit ok;
    logic [15:0] exp_bcd;
    for (int v = 0; v <= 9995; v += 5) begin
      apply(v, ok);
      exp_bcd = to_bcd(v);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL sweep_timeout score=%0d got busy=%b", v, busy);
      end else if (bcd !== exp_bcd || ovf !== 1'b0) begin
        errors++; $display("FAIL sweep_bcd score=%0d got %h ovf=%b exp %h ovf=0", v, bcd, ovf, exp_bcd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_clamp();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
